// File: rtl/regport_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package regport_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t XZR_ADDR = 5'd31;

endpackage

// File: rtl/regport_rr_arbiter_if.sv
// Request/response/read-port bundle for regport_rr_arbiter.
// Optional write-forwarding signals appear when REGPORT_BYPASS_EN is defined.
interface regport_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int ID_W  = $clog2(NREQ)
);
    import regport_pkg::*;

    logic [NREQ-1:0]            req_valid;
    reg_addr_t [NREQ-1:0]       req_addr;
    logic [NREQ-1:0]            req_ready;
    reg_addr_t                  mux_sel;
    logic [WIDTH-1:0]           mux_data;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH-1:0]           rsp_data;
    logic                       rsp_ready;
`ifdef REGPORT_BYPASS_EN
    logic                       wr_en;
    reg_addr_t                  wr_addr;
    logic [WIDTH-1:0]           wr_data;

    modport slave (
        input  req_valid, req_addr, mux_data, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );
    modport master (
        output req_valid, req_addr, mux_data, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );
`else
    modport slave (
        input  req_valid, req_addr, mux_data, rsp_ready,
        output req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );
    modport master (
        output req_valid, req_addr, mux_data, rsp_ready,
        input  req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );
`endif

endinterface

// File: rtl/regport_rr_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, searching cyclically.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NREQ);
            end
        end
        if (en && found) grant = NREQ'(1) << idx;
    end

endmodule

// File: rtl/regport_rr_arbiter.sv
// Round-robin sharing of one 32:1 register read port among NREQ requesters.
// Define REGPORT_BYPASS_EN to forward a same-cycle register write into the response.
module regport_rr_arbiter
    import regport_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int ID_W  = $clog2(NREQ)
) (
    input logic                 clk,
    input logic                 reset_n,
    regport_rr_arbiter_if.slave bus
);

`ifdef REGPORT_BYPASS_EN
    function automatic logic [WIDTH-1:0] load_data(
        input reg_addr_t        addr,
        input logic [WIDTH-1:0] rdata,
        input logic             fwd_en,
        input reg_addr_t        fwd_addr,
        input logic [WIDTH-1:0] fwd_data
    );
        if (addr == XZR_ADDR) return '0;
        if (fwd_en && (fwd_addr == addr)) return fwd_data;
        return rdata;
    endfunction
`else
    function automatic logic [WIDTH-1:0] load_data(
        input reg_addr_t        addr,
        input logic [WIDTH-1:0] rdata
    );
        if (addr == XZR_ADDR) return '0;
        return rdata;
    endfunction
`endif

    logic [ID_W-1:0]  ptr_q;
    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             hs;
    logic             adv2;
    logic             acc1;
    logic [WIDTH-1:0] ld_data;

    logic             vld_p1;
    logic [ID_W-1:0]  id_p1;
    reg_addr_t        addr_p1;

    logic             vld_p2;
    logic [ID_W-1:0]  id_p2;
    logic [WIDTH-1:0] data_p2;

    assign adv2 = vld_p1 & (~vld_p2 | bus.rsp_ready);
    assign acc1 = ~vld_p1 | adv2;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .en    (acc1),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign hs = |gnt;

    always_comb begin
`ifdef REGPORT_BYPASS_EN
        ld_data = load_data(addr_p1, bus.mux_data, bus.wr_en, bus.wr_addr, bus.wr_data);
`else
        ld_data = load_data(addr_p1, bus.mux_data);
`endif
    end

    // Pointer moves past the winner only on an accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Stage 1: accepted request; addr_p1 drives the read-port select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            addr_p1 <= '0;
        end else if (hs) begin
            vld_p1  <= 1'b1;
            id_p1   <= gnt_idx;
            addr_p1 <= bus.req_addr[gnt_idx];
        end else if (adv2) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage 2: response register, held while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            id_p2   <= '0;
            data_p2 <= '0;
        end else if (adv2) begin
            vld_p2  <= 1'b1;
            id_p2   <= id_p1;
            data_p2 <= ld_data;
        end else if (bus.rsp_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.mux_sel   = addr_p1;
    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_id    = id_p2;
    assign bus.rsp_data  = data_p2;

endmodule

// File: tb/tb_regport_rr_arbiter.sv
// Bench for regport_rr_arbiter: directed table, hand sequences and a randomized scoreboard run.
module tb_regport_rr_arbiter;
    import regport_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regport_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] rf [NUM_REGS];
    assign bus.mux_data = rf[bus.mux_sel];

    regport_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          id;
        int          addr;
        logic [63:0] rdata;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] data;
    } exp_t;

    vec_t vecs[4];
    exp_t q[$];
    int   mptr;

    // One cycle of the reference model: sampled at the falling edge.
    task automatic model_step(input string tag);
        logic [NREQ-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = -1;
        if ((bus.req_valid != 0) && ((q.size() < 2) || bus.rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && bus.req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
            exp_rdy[g] = 1'b1;
        end
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        if (bus.rsp_valid) begin
            chk({tag, "_rsp_pending"}, 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(q[0].id));
                chk({tag, "_rsp_data"}, bus.rsp_data, q[0].data);
                if (bus.rsp_ready) void'(q.pop_front());
            end
        end
        if (g >= 0) begin
            exp_t e;
            e.id   = g;
            e.data = (bus.req_addr[g] == XZR_ADDR) ? 64'h0 : rf[bus.req_addr[g]];
            q.push_back(e);
            mptr = (g + 1) % NREQ;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
`ifdef REGPORT_BYPASS_EN
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
`endif
        for (int i = 0; i < NUM_REGS; i++) rf[i] = {$urandom(), $urandom()};

        vecs[0] = '{1, 17, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444};
        vecs[1] = '{2, 31, 64'hFFFF, 64'h0};
        vecs[2] = '{3, 0, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
        vecs[3] = '{0, 5, 64'hA5, 64'hA5};

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("reset_rsp_data", bus.rsp_data, 64'h0);
        chk("reset_mux_sel", 64'(bus.mux_sel), 64'(0));
        chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
        cyc();
        reset_n = 1'b1;

        // All four requesting continuously
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            if (k == 0) begin
                bus.rsp_ready = 1'b1;
                bus.req_valid = 4'b1111;
                for (int i = 0; i < NREQ; i++) bus.req_addr[i] = 5'(i * 3 + 1);
            end
            if (k == 5) bus.req_valid = '0;
            @(negedge clk);
            if (k < 5) chk("rr_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
            if (k >= 2 && k < 7) begin
                chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'(1));
                chk("rr_rsp_id", 64'(bus.rsp_id), 64'((k - 2) % 4));
                chk("rr_rsp_data", bus.rsp_data, rf[((k - 2) % 4) * 3 + 1]);
            end
            if (k == 7) chk("rr_drained", 64'(bus.rsp_valid), 64'(0));
        end

        // Table of single-requester transactions
        for (int r = 0; r < 4; r++) begin
            rf[vecs[r].addr] = vecs[r].rdata;
            cyc();
            bus.req_valid = 4'(1 << vecs[r].id);
            bus.req_addr[vecs[r].id] = 5'(vecs[r].addr);
            @(negedge clk);
            chk("vec_ready", 64'(bus.req_ready), 64'(1 << vecs[r].id));
            cyc();
            bus.req_valid = '0;
            @(negedge clk);
            chk("vec_mux_sel", 64'(bus.mux_sel), 64'(vecs[r].addr));
            cyc();
            @(negedge clk);
            chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("vec_rsp_id", 64'(bus.rsp_id), 64'(vecs[r].id));
            chk("vec_rsp_data", bus.rsp_data, vecs[r].exp);
        end
        cyc();

        // Backpressure: pointer now 1, requesters 1 and 2 compete
        bus.req_valid   = 4'b0110;
        bus.req_addr[1] = 5'd10;
        bus.req_addr[2] = 5'd11;
        @(negedge clk);
        chk("bp_grant0", 64'(bus.req_ready), 64'(4'b0010));
        cyc();
        @(negedge clk);
        chk("bp_grant1", 64'(bus.req_ready), 64'(4'b0100));
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("bp_hold_id", 64'(bus.rsp_id), 64'(1));
            chk("bp_hold_data", bus.rsp_data, rf[10]);
            chk("bp_hold_mux_sel", 64'(bus.mux_sel), 64'(11));
            chk("bp_no_ready", 64'(bus.req_ready), 64'(0));
        end
        cyc();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp_first_id", 64'(bus.rsp_id), 64'(1));
        cyc();
        @(negedge clk);
        chk("bp_second_valid", 64'(bus.rsp_valid), 64'(1));
        chk("bp_second_id", 64'(bus.rsp_id), 64'(2));
        chk("bp_second_data", bus.rsp_data, rf[11]);
        cyc();
        @(negedge clk);
        chk("bp_no_dup", 64'(bus.rsp_valid), 64'(0));

        // Reset while both stages are full
        cyc();
        bus.rsp_ready   = 1'b0;
        bus.req_valid   = 4'b0010;
        bus.req_addr[1] = 5'd3;
        cyc();
        cyc();
        bus.req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("arst_mux_sel", 64'(bus.mux_sel), 64'(0));
        chk("arst_req_ready", 64'(bus.req_ready), 64'(0));
        cyc();
        reset_n         = 1'b1;
        bus.rsp_ready   = 1'b1;
        bus.req_valid   = 4'b1010;
        bus.req_addr[1] = 5'd4;
        bus.req_addr[3] = 5'd6;
        @(negedge clk);
        chk("arst_ptr_zero", 64'(bus.req_ready), 64'(4'b0010));
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("arst_dropped", 64'(bus.rsp_valid), 64'(0));
        cyc();
        @(negedge clk);
        chk("arst_new_id", 64'(bus.rsp_id), 64'(1));
        chk("arst_new_data", bus.rsp_data, rf[4]);
        cyc();
        @(negedge clk);
        chk("arst_idle", 64'(bus.rsp_valid), 64'(0));

        // Randomized run against the scoreboard
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        mptr = 0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            cyc();
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++)
                bus.req_addr[i] = ($urandom_range(0, 7) == 0) ? XZR_ADDR : 5'($urandom_range(0, 31));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_step("rand");
        end
        for (int c = 0; c < 4; c++) begin
            cyc();
            bus.req_valid = '0;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            model_step("drain");
        end
        chk("rand_all_delivered", 64'(q.size()), 64'(0));

`ifdef REGPORT_BYPASS_EN
        // Same-cycle write forwarding, then a non-matching write
        rf[7] = 64'h0;
        for (int r = 0; r < 2; r++) begin
            cyc();
            bus.req_valid   = 4'b0001;
            bus.req_addr[0] = 5'd7;
            @(negedge clk);
            chk("byp_ready", 64'(bus.req_ready), 64'(1));
            cyc();
            bus.req_valid = '0;
            bus.wr_en     = 1'b1;
            bus.wr_addr   = (r == 0) ? 5'd7 : 5'd8;
            bus.wr_data   = 64'h1234;
            cyc();
            bus.wr_en = 1'b0;
            @(negedge clk);
            chk("byp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("byp_rsp_data", bus.rsp_data, (r == 0) ? 64'h1234 : 64'h0);
        end
`endif

        cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/regport_rr_arbiter.md
Name: regport_rr_arbiter

Overview:
- Shares one 32:1 register-file read port (the WIDTH-bit-wide mux32_1 bank and its 5-bit select) among NREQ requesters.
- Round-robin arbitration, valid/ready request handshake, two-stage pipeline.
- Single response bus tagged with requester id, with backpressure.
- Sits between the register file and the decode/operand-fetch consumers: drives the mux select and captures the mux output.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- WIDTH, 64, register data width; must equal the read-port mux width.
- ID_W, $clog2(NREQ), width of the response id tag.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester read request
- req_addr  input  NREQ x 5  per-requester register number
- req_ready  output  NREQ  one-hot request accept, asserted in the cycle of handshake
- mux_sel  output  5  select driven to the read-port mux; registered
- mux_data  input  WIDTH  combinational output of the read-port mux
- rsp_valid  output  1  response valid
- rsp_id  output  ID_W  requester index of the response
- rsp_data  output  WIDTH  read data
- rsp_ready  input  1  consumer accepts the response

Behaviour:
- Reset (asynchronous, reset_n low): all outputs and state are cleared.
  - rsp_valid=0, rsp_id=0, rsp_data=0, mux_sel=0, req_ready=0.
  - Stage-1 valid (s1_v)=0 and round-robin pointer=0.
  - Requests in flight when reset asserts are dropped, with no response.
- Pipeline:
  - Stage 1 holds {s1_v, s1_id, s1_addr}; mux_sel is the registered s1_addr.
  - Stage 2 is the response register.
- Advance conditions:
  - adv2 = s1_v & (~rsp_valid | rsp_ready).
  - acc1 = ~s1_v | adv2.
- Arbitration:
  - Among req_valid bits, grant the first set bit at or after the pointer, searching cyclically.
  - req_ready[g] = acc1 & req_valid[g], for the granted g only; at most one bit is high.
  - req_ready is combinational from req_valid, state and rsp_ready.
- On handshake (cycle T):
  - At the edge: s1_v=1, s1_id=g, mux_sel=req_addr[g], pointer=(g+1) mod NREQ.
  - The pointer is unchanged when no handshake occurs.
- Cycle T+1:
  - mux_data is valid.
  - If adv2, at the edge: rsp_valid=1, rsp_id=s1_id, rsp_data=mux_data.
- Zero register:
  - If s1_addr==31 (XZR), rsp_data loads 0 regardless of mux_data.
- Response timing:
  - The response is visible at T+2 at minimum (latency 2).
  - Throughput is 1 request/cycle while rsp_ready=1.
- Backpressure:
  - While rsp_valid & ~rsp_ready, rsp_* hold stable.
  - Stage 1 holds and mux_sel holds.
  - req_ready is 0 if stage 1 is occupied.
- Response handshake:
  - Completes when rsp_valid & rsp_ready.
  - The same cycle may load the next response from stage 1.
  - Otherwise rsp_valid falls.
- No requests: s1_v clears when it advances; mux_sel keeps its last value.
- Requester contract: req_addr must be stable while req_valid is high and not yet accepted. The arbiter does not require this, since it samples only at handshake.
- NREQ not a power of two: the pointer wraps at NREQ-1 to 0.

Optional Feature:
- Macro: REGPORT_BYPASS_EN.
- When defined:
  - Added inputs: wr_en (1), wr_addr (5), wr_data (WIDTH), driven by the register-file write port.
  - In the stage-2 load cycle, if wr_en & wr_addr==s1_addr & s1_addr!=31, rsp_data loads wr_data instead of mux_data.
  - This forwards a same-cycle write.
- When undefined:
  - The ports are absent.
  - rsp_data always takes mux_data (or 0 for register 31).

Decomposition:
- Package regport_pkg holds:
  - REG_ADDR_W=5
  - XZR_ADDR=5'd31
  - NUM_REGS=32
  - typedef reg_addr_t (logic [4:0])
- Sub-module rr_arbiter #(NREQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The pointer register and the pipeline stay in the top module.

Test Plan:
1. Single request: req_valid=0001, addr=5, mux_data=64'hA5 when mux_sel==5, rsp_ready=1.
   -> req_ready[0] in cycle 0; mux_sel=5 at cycle 1; rsp_valid, rsp_id=0, rsp_data=64'hA5 at cycle 2.
2. All four requesting continuously, rsp_ready=1.
   -> grants in order 0,1,2,3,0; one response per cycle; rsp_id sequence 0,1,2,3,0.
3. Backpressure: rsp_ready=0 for 3 cycles after the first response.
   -> rsp_* stable; the second request is held in stage 1 with mux_sel stable; req_ready all 0.
   -> After rsp_ready=1, responses resume in order with no loss or duplication.
4. Register 31: addr=31, mux_data=64'hFFFF.
   -> rsp_data=0.
5. Reset mid-operation: reset_n low while stage 1 and stage 2 are valid.
   -> rsp_valid=0 and mux_sel=0 immediately (asynchronous).
   -> After release, the pointer is 0: with req_valid=1010, requester 1 is granted first.
6. With REGPORT_BYPASS_EN defined: request addr=7 with wr_en=1, wr_addr=7, wr_data=64'h1234 in the stage-2 load cycle, and mux_data=64'h0.
   -> rsp_data=64'h1234.
   -> Repeat with wr_addr=8: rsp_data=64'h0.
